// File: rtl/contador_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// pacote_display : mode codes, digit count and BCD helpers for the display
// Revision 1.0
// ============================================================================
package pacote_display;

    localparam logic [1:0] MODO_LIMPA = 2'b00;
    localparam logic [1:0] MODO_SOBE  = 2'b01;
    localparam logic [1:0] MODO_DESCE = 2'b10;
    localparam logic [1:0] MODO_PAUSA = 2'b11;

    localparam int NUM_DIGITOS      = 4;
    localparam int LARGURA_CONTAGEM = 4 * NUM_DIGITOS;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
    function automatic logic [6:0] bcd_para_7seg(input logic [3:0] digito);
        logic [6:0] padrao;
        case (digito)
            4'd0:    padrao = 7'b1000000;
            4'd1:    padrao = 7'b1111001;
            4'd2:    padrao = 7'b0100100;
            4'd3:    padrao = 7'b0110000;
            4'd4:    padrao = 7'b0011001;
            4'd5:    padrao = 7'b0010010;
            4'd6:    padrao = 7'b0000010;
            4'd7:    padrao = 7'b1111000;
            4'd8:    padrao = 7'b0000000;
            4'd9:    padrao = 7'b0010000;
            default: padrao = 7'b1111111;
        endcase
        return padrao;
    endfunction

    function automatic logic [LARGURA_CONTAGEM-1:0] bcd_incrementa(
        input logic [LARGURA_CONTAGEM-1:0] valor);
        logic [LARGURA_CONTAGEM-1:0] r;
        logic                        vai;
        r   = valor;
        vai = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (vai) begin
                if (valor[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = valor[4*i +: 4] + 4'd1;
                    vai         = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [LARGURA_CONTAGEM-1:0] bcd_decrementa(
        input logic [LARGURA_CONTAGEM-1:0] valor);
        logic [LARGURA_CONTAGEM-1:0] r;
        logic                        empresta;
        r        = valor;
        empresta = 1'b1;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (empresta) begin
                if (valor[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = valor[4*i +: 4] - 4'd1;
                    empresta    = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/contador_bcd_display_if.sv
`default_nettype none
// ============================================================================
// contador_bcd_display_if : divider ticks, mode switches and display outputs
// Revision 1.0
// ============================================================================
interface contador_bcd_display_if;
    import pacote_display::*;

    logic                        tick_lento;
    logic                        tick_rapido;
    logic                        ch1;
    logic                        ch0;
    logic [NUM_DIGITOS-1:0]      anodo;
    logic [6:0]                  segmentos;
    logic [LARGURA_CONTAGEM-1:0] contagem;

    modport master (
        output tick_lento, tick_rapido, ch1, ch0,
        input  anodo, segmentos, contagem
    );

    modport slave (
        input  tick_lento, tick_rapido, ch1, ch0,
        output anodo, segmentos, contagem
    );
endinterface
`default_nettype wire

// File: rtl/contador_bcd_display_sincronizador.sv
`default_nettype none
// ============================================================================
// sincronizador_borda : 2-flop synchroniser plus edge flop (rising-edge pulse)
// Revision 1.0
// ============================================================================
module sincronizador_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic nivel,
    output logic pulso
);
    logic [2:0] sinc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc_q <= 3'b000;
        end else begin
            sinc_q <= {sinc_q[1:0], entrada};
        end
    end

    assign nivel = sinc_q[1];
    assign pulso = sinc_q[1] & ~sinc_q[2];
endmodule
`default_nettype wire

// File: rtl/contador_bcd_display.sv
`default_nettype none
// ============================================================================
// contador_bcd_display : 4-digit BCD up/down counter with multiplexed display
// Revision 1.0
// ============================================================================
module contador_bcd_display
    import pacote_display::*;
#(
    parameter bit ANODO_ATIVO = 1'b0,
    parameter bit SEG_ATIVO   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    contador_bcd_display_if.slave  bus
);
    localparam logic [NUM_DIGITOS-1:0] C_ANODO_INATIVO = {NUM_DIGITOS{~ANODO_ATIVO}};
    localparam logic [6:0]             C_SEG_INATIVO   = {7{~SEG_ATIVO}};

    // Assertion is immediate; release is retimed so every flop leaves reset together.
    logic [1:0] rst_sinc_q;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sinc_q <= 2'b00;
        end else begin
            rst_sinc_q <= {rst_sinc_q[0], 1'b1};
        end
    end

    assign w_rst_n = rst_sinc_q[1];

    logic w_pulso_lento, w_pulso_rapido;
    logic w_nivel_lento_unused, w_nivel_rapido_unused;
    logic w_ch1, w_ch0, w_ch1_pulso_unused, w_ch0_pulso_unused;

    sincronizador_borda u_sinc_lento (
        .clk(clk), .rst_n(w_rst_n), .entrada(bus.tick_lento),
        .nivel(w_nivel_lento_unused), .pulso(w_pulso_lento)
    );

    sincronizador_borda u_sinc_rapido (
        .clk(clk), .rst_n(w_rst_n), .entrada(bus.tick_rapido),
        .nivel(w_nivel_rapido_unused), .pulso(w_pulso_rapido)
    );

    sincronizador_borda u_sinc_ch1 (
        .clk(clk), .rst_n(w_rst_n), .entrada(bus.ch1),
        .nivel(w_ch1), .pulso(w_ch1_pulso_unused)
    );

    sincronizador_borda u_sinc_ch0 (
        .clk(clk), .rst_n(w_rst_n), .entrada(bus.ch0),
        .nivel(w_ch0), .pulso(w_ch0_pulso_unused)
    );

    logic [1:0]                  w_modo;
    logic [LARGURA_CONTAGEM-1:0] contagem_q, contagem_d;
    logic [1:0]                  indice_q;
    logic [NUM_DIGITOS-1:0]      anodo_q, w_anodo_sel;
    logic [6:0]                  segmentos_q, w_seg_sel;
    logic [3:0]                  w_digito;

    assign w_modo = {w_ch1, w_ch0};

    always_comb begin
        contagem_d = contagem_q;
        case (w_modo)
            MODO_LIMPA: contagem_d = '0;
            MODO_SOBE:  if (w_pulso_lento) contagem_d = bcd_incrementa(contagem_q);
            MODO_DESCE: if (w_pulso_lento) contagem_d = bcd_decrementa(contagem_q);
            default:    contagem_d = contagem_q;
        endcase
    end

    // A scan pulse latches the digit at the current index, then moves on.
    assign w_digito  = contagem_q[{indice_q, 2'b00} +: 4];
    assign w_seg_sel = SEG_ATIVO ? ~bcd_para_7seg(w_digito) : bcd_para_7seg(w_digito);

    always_comb begin
        w_anodo_sel           = C_ANODO_INATIVO;
        w_anodo_sel[indice_q] = ANODO_ATIVO;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            contagem_q  <= '0;
            indice_q    <= 2'd0;
            anodo_q     <= C_ANODO_INATIVO;
            segmentos_q <= C_SEG_INATIVO;
        end else begin
            contagem_q <= contagem_d;
            if (w_modo == MODO_LIMPA) begin
                indice_q    <= 2'd0;
                anodo_q     <= C_ANODO_INATIVO;
                segmentos_q <= C_SEG_INATIVO;
            end else if (w_pulso_rapido) begin
                indice_q    <= indice_q + 2'd1;
                anodo_q     <= w_anodo_sel;
                segmentos_q <= w_seg_sel;
            end
        end
    end

    assign bus.contagem  = contagem_q;
    assign bus.anodo     = anodo_q;
    assign bus.segmentos = segmentos_q;
endmodule
`default_nettype wire

// File: tb/tb_contador_bcd_display.sv
`default_nettype none
// ============================================================================
// tb_contador_bcd_display : scoreboard bench for the BCD counter and display
// Revision 1.0
// ============================================================================
module tb_contador_bcd_display;
    import pacote_display::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    contador_bcd_display_if bus_if ();

    contador_bcd_display #(
        .ANODO_ATIVO(1'b0),
        .SEG_ATIVO  (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    // tipo: 0 = contagem, 1 = anodo, 2 = segmentos
    typedef struct {
        int          tipo;
        logic [15:0] valor;
        int          prazo;
    } item_t;

    item_t       fila[$];
    item_t       it_mon;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] cont_modelo = 16'h0000;
    logic [15:0] cont_visivel = 16'h0000;
    int          idx_modelo = 0;
    logic [1:0]  modo_modelo = 2'b01;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, esp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_esperado(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int de_bcd(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] para_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Outputs are sampled mid-cycle; each queued expectation is due on a cycle number.
    always @(negedge clk) begin
        while (fila.size() > 0 && fila[0].prazo <= cyc) begin
            it_mon = fila.pop_front();
            case (it_mon.tipo)
                0: begin
                    chk("contagem", bus_if.contagem, it_mon.valor);
                    cont_visivel = it_mon.valor;
                end
                1: chk("anodo", {12'h000, bus_if.anodo}, it_mon.valor);
                default: chk("segmentos", {9'h000, bus_if.segmentos}, it_mon.valor);
            endcase
        end
        if (bus_if.contagem !== cont_visivel) begin
            chk("contagem_estavel", bus_if.contagem, cont_visivel);
            cont_visivel = bus_if.contagem;
        end
    end

    task automatic espera(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic aplica_lento(input int k);
        logic [15:0] novo;
        case (modo_modelo)
            2'b00:   novo = 16'h0000;
            2'b01:   novo = para_bcd((de_bcd(cont_modelo) + 1) % 10000);
            2'b10:   novo = para_bcd((de_bcd(cont_modelo) + 9999) % 10000);
            default: novo = cont_modelo;
        endcase
        if (novo != cont_modelo) begin
            cont_modelo = novo;
            fila.push_back('{0, novo, k + 3});
        end
    endtask

    task automatic aplica_rapido(input int k);
        logic [3:0] nib;
        if (modo_modelo == 2'b00) begin
            fila.push_back('{1, 16'h000F, k + 3});
            fila.push_back('{2, 16'h007F, k + 3});
        end else begin
            nib = cont_modelo[4*idx_modelo +: 4];
            fila.push_back('{1, {12'h000, 4'hF ^ (4'b0001 << idx_modelo)}, k + 3});
            fila.push_back('{2, {9'h000, seg_esperado(nib)}, k + 3});
            idx_modelo = (idx_modelo + 1) % 4;
        end
    endtask

    task automatic set_modo(input logic [1:0] m);
        bus_if.ch1  = m[1];
        bus_if.ch0  = m[0];
        modo_modelo = m;
        if (m == 2'b00) begin
            if (cont_modelo != 16'h0000) begin
                cont_modelo = 16'h0000;
                fila.push_back('{0, 16'h0000, cyc + 3});
            end
            fila.push_back('{1, 16'h000F, cyc + 3});
            fila.push_back('{2, 16'h007F, cyc + 3});
            idx_modelo = 0;
        end
    endtask

    task automatic pulso_lento(input int alto, input int baixo);
        bus_if.tick_lento = 1'b1;
        aplica_lento(cyc);
        espera(alto);
        bus_if.tick_lento = 1'b0;
        espera(baixo);
    endtask

    task automatic pulso_rapido(input int alto, input int baixo);
        bus_if.tick_rapido = 1'b1;
        aplica_rapido(cyc);
        espera(alto);
        bus_if.tick_rapido = 1'b0;
        espera(baixo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.tick_lento  = 1'b0;
        bus_if.tick_rapido = 1'b0;
        bus_if.ch1         = 1'b0;
        bus_if.ch0         = 1'b1;
        espera(3);
        chk("reset_contagem", bus_if.contagem, 16'h0000);
        chk("reset_anodo", {12'h000, bus_if.anodo}, 16'h000F);
        chk("reset_seg", {9'h000, bus_if.segmentos}, 16'h007F);
        rst_n = 1'b1;
        espera(5);

        for (int i = 0; i < 12; i++) pulso_lento(3, 3);
        espera(4);
        chk("conta_12", bus_if.contagem, 16'h0012);

        set_modo(2'b00); espera(5);
        set_modo(2'b01); espera(5);
        for (int i = 0; i < 427; i++) pulso_lento(2, 2);
        espera(4);
        chk("conta_0427", bus_if.contagem, 16'h0427);

        set_modo(2'b11); espera(5);
        for (int i = 0; i < 5; i++) pulso_rapido(2, 2);
        pulso_lento(2, 2);
        espera(4);
        chk("pausa_retem", bus_if.contagem, 16'h0427);

        // Clear arrives together with both tick edges.
        bus_if.tick_lento  = 1'b1;
        bus_if.tick_rapido = 1'b1;
        set_modo(2'b00);
        aplica_lento(cyc);
        aplica_rapido(cyc);
        espera(3);
        bus_if.tick_lento  = 1'b0;
        bus_if.tick_rapido = 1'b0;
        espera(3);
        pulso_rapido(2, 2);
        espera(4);
        set_modo(2'b01); espera(5);
        pulso_rapido(2, 2);
        espera(4);
        chk("sai_limpa_anodo", {12'h000, bus_if.anodo}, 16'h000E);

        set_modo(2'b10); espera(5);
        pulso_lento(2, 2); espera(4);
        chk("desce_0000_9999", bus_if.contagem, 16'h9999);
        pulso_lento(2, 2); espera(4);
        set_modo(2'b01); espera(5);
        pulso_lento(2, 2); pulso_lento(2, 2); espera(4);
        chk("sobe_9999_0000", bus_if.contagem, 16'h0000);

        for (int i = 0; i < 999; i++) pulso_lento(2, 2);
        espera(4);
        chk("conta_0999", bus_if.contagem, 16'h0999);
        pulso_lento(2, 2); espera(4);
        chk("vai_um_1000", bus_if.contagem, 16'h1000);
        set_modo(2'b10); espera(5);
        pulso_lento(2, 2); espera(4);
        chk("empresta_0999", bus_if.contagem, 16'h0999);

        set_modo(2'b01); espera(5);
        bus_if.tick_lento = 1'b1;
        aplica_lento(cyc);
        espera(100);
        bus_if.tick_lento = 1'b0;
        espera(5);
        chk("alto_100_ciclos", bus_if.contagem, 16'h1000);

        pulso_rapido(2, 2);
        espera(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        fila.delete();
        cont_modelo  = 16'h0000;
        cont_visivel = 16'h0000;
        idx_modelo   = 0;
        #1;
        chk("reset_async_contagem", bus_if.contagem, 16'h0000);
        chk("reset_async_anodo", {12'h000, bus_if.anodo}, 16'h000F);
        chk("reset_async_seg", {9'h000, bus_if.segmentos}, 16'h007F);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        espera(5);
        pulso_lento(2, 2); espera(4);
        chk("pos_reset_0001", bus_if.contagem, 16'h0001);

        espera(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
